// File: rtl/mvu_pkg.sv
// Shared MVU accelerator constants and types: memory geometry, write-arbiter FSM states,
// and a small helper that sizes index and counter vectors.
package mvu_pkg;

    localparam int NMVU    = 8;
    localparam int BDBANKA = 15;
    localparam int BDBANKW = 64;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } wrc_arb_state_t;

    // Width needed to hold 0..n-1; never collapses to zero bits.
    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvu_wrc_arbiter_if.sv
// Bundle of transposer write requests and MVU data-memory write-port signals.
// master = transposer/MVU side, slave = arbiter.
interface mvu_wrc_arbiter_if
    import mvu_pkg::*;
#(
    parameter int NREQ   = NMVU,
    parameter int ADDR_W = BDBANKA,
    parameter int DATA_W = BDBANKW
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_last;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_word;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        wrc_en;
    logic [ADDR_W-1:0]      wrc_addr;
    logic [DATA_W-1:0]      wrc_word;
    logic [NREQ-1:0]        wrc_grnt;

    modport master (
        output req_valid, req_last, req_addr, req_word, wrc_grnt,
        input  req_ready, wrc_en, wrc_addr, wrc_word
    );

    modport slave (
        input  req_valid, req_last, req_addr, req_word, wrc_grnt,
        output req_ready, wrc_en, wrc_addr, wrc_word
    );

endinterface

// File: rtl/mvu_wrc_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping cyclically.
// Shared with the MVU read-port arbiter.
module rr_pick
    import mvu_pkg::*;
#(
    parameter int NREQ  = NMVU,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req[(32'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                idx   = IDX_W'((32'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/mvu_wrc_arbiter.sv
// Round-robin arbiter serialising transposer write bursts onto the shared MVU wrc port.
// Optional MVU_WRC_ARB_STATS_EN adds per-requester beat and stall counters.
module mvu_wrc_arbiter
    import mvu_pkg::*;
#(
    parameter int NREQ      = NMVU,
    parameter int ADDR_W    = BDBANKA,
    parameter int DATA_W    = BDBANKW,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    mvu_wrc_arbiter_if.slave    bus,
    output logic                busy
`ifdef MVU_WRC_ARB_STATS_EN
    ,
    output logic [NREQ*32-1:0]  stat_beats,
    output logic [31:0]         stat_stall
`endif
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int CNT_W = idx_width(MAX_BURST);

    wrc_arb_state_t    state, state_nxt;
    logic [IDX_W-1:0]  owner, owner_nxt;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_word;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              out_accept;
    logic              beat_take;
    logic              burst_end;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // A grant-low stall frees no slot, so ready drops combinationally with wrc_grnt.
    assign out_accept = out_valid & bus.wrc_grnt[out_idx];
    assign beat_take  = (state == BURST) & bus.req_valid[owner] & (~out_valid | out_accept);
    assign burst_end  = beat_take & (bus.req_last[owner] | (beat_cnt == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = BURST;
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (beat_take) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
                if (burst_end) begin
                    state_nxt  = DRAIN;
                    rr_ptr_nxt = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
            end
            DRAIN: begin
                if (out_accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_addr  <= '0;
            out_word  <= '0;
        end else if (beat_take) begin
            out_valid <= 1'b1;
            out_idx   <= owner;
            out_addr  <= bus.req_addr[owner*ADDR_W +: ADDR_W];
            out_word  <= bus.req_word[owner*DATA_W +: DATA_W];
        end else if (out_accept) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.req_ready = beat_take ? (NREQ'(1) << owner) : '0;
    assign bus.wrc_en    = out_valid ? (NREQ'(1) << out_idx) : '0;
    assign bus.wrc_addr  = out_addr;
    assign bus.wrc_word  = out_word;
    assign busy          = (state != IDLE) | out_valid;

`ifdef MVU_WRC_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else begin
            if (out_accept) begin
                stat_beats[out_idx*32 +: 32] <= stat_beats[out_idx*32 +: 32] + 32'd1;
            end
            if (out_valid && !out_accept) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

    // Requesters must keep a beat presented until it is taken.
    for (genvar i = 0; i < NREQ; i++) begin : g_hold
        a_hold_valid: assert property (@(posedge clk)
            (!rst && bus.req_valid[i] && !bus.req_ready[i]) |=> bus.req_valid[i]);
    end

endmodule

// File: tb/tb_mvu_wrc_arbiter.sv
// Bench for mvu_wrc_arbiter: transaction-level requester queues, a behavioural arbiter model
// checked every cycle, and literal expectations for the directed scenarios.
module tb_mvu_wrc_arbiter;
    import mvu_pkg::*;

    localparam int N  = NMVU;
    localparam int AW = BDBANKA;
    localparam int DW = BDBANKW;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef MVU_WRC_ARB_STATS_EN
    logic [N*32-1:0] stat_beats;
    logic [31:0]     stat_stall;
`endif

    always #5 clk = ~clk;

    mvu_wrc_arbiter_if #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mvu_wrc_arbiter #(
        .NREQ      (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy)
`ifdef MVU_WRC_ARB_STATS_EN
        ,
        .stat_beats (stat_beats),
        .stat_stall (stat_stall)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] word;
        logic          last;
    } beat_t;

    beat_t q[N][$];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model: who owns the port, whether the owner has finished, and the held beat.
    int            m_owner = -1;
    bit            m_done  = 0;
    int            m_cnt   = 0;
    int            m_ptr   = 0;
    bit            m_hv    = 0;
    int            m_hi    = 0;
    logic [AW-1:0] m_ha    = '0;
    logic [DW-1:0] m_hw    = '0;
    int unsigned   m_beats[N];
    int unsigned   m_stall = 0;

    int            lg_en[$], lg_ready[$], lg_busy[$];
    logic [AW-1:0] lg_addr[$];
    logic [DW-1:0] lg_word[$];
    int            g_idx[$];
    logic [AW-1:0] g_addr[$];

    logic [N-1:0]  seen_ready;
    bit            seen_rst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_burst(input int r, input int len, input int base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.addr = AW'(base + k);
            b.word = DW'({$urandom(), $urandom()});
            b.last = (k == len - 1);
            q[r].push_back(b);
        end
    endtask

    task automatic drive_req();
        logic [N-1:0]    v, l;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] w;
        v = '0; l = '0; a = '0; w = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                v[i]           = 1'b1;
                l[i]           = q[i][0].last;
                a[i*AW +: AW]  = q[i][0].addr;
                w[i*DW +: DW]  = q[i][0].word;
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_addr  = a;
        bus.req_word  = w;
    endtask

    function automatic bit model_idle();
        return (m_owner < 0) && !m_hv;
    endfunction

    task automatic compare();
        logic [N-1:0] er, ee;
        bit acc;
        acc = m_hv && bus.wrc_grnt[m_hi];
        er  = '0;
        ee  = '0;
        if (m_owner >= 0 && !m_done && bus.req_valid[m_owner] && (!m_hv || acc)) er[m_owner] = 1'b1;
        if (m_hv) ee[m_hi] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("wrc_en", 64'(bus.wrc_en), 64'(ee));
        chk("busy", 64'(busy), 64'(!model_idle()));
        if (m_hv) begin
            chk("wrc_addr", 64'(bus.wrc_addr), 64'(m_ha));
            chk("wrc_word", 64'(bus.wrc_word), 64'(m_hw));
        end
`ifdef MVU_WRC_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("stat_beats", 64'(stat_beats[i*32 +: 32]), 64'(m_beats[i]));
        chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
    endtask

    task automatic model_step();
        bit acc, take;
        if (rst) begin
            m_owner = -1; m_done = 0; m_cnt = 0; m_ptr = 0;
            m_hv = 0; m_hi = 0; m_ha = '0; m_hw = '0;
            m_stall = 0;
            for (int i = 0; i < N; i++) m_beats[i] = 0;
            return;
        end
        acc  = m_hv && bus.wrc_grnt[m_hi];
        take = (m_owner >= 0) && !m_done && bus.req_valid[m_owner] && (!m_hv || acc);
        if (acc) m_beats[m_hi]++;
        if (m_hv && !acc) m_stall++;
        if (take) begin
            m_hv = 1; m_hi = m_owner;
            m_ha = bus.req_addr[m_owner*AW +: AW];
            m_hw = bus.req_word[m_owner*DW +: DW];
        end else if (acc) begin
            m_hv = 0;
        end
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && bus.req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_cnt   = 0;
                    m_done  = 0;
                end
            end
        end else if (m_done) begin
            if (acc) m_owner = -1;
        end else if (take) begin
            m_cnt++;
            if (bus.req_last[m_owner] || m_cnt == MB) begin
                m_ptr  = (m_owner + 1) % N;
                m_done = 1;
            end
        end
    endtask

    task automatic tick();
        drive_req();
        @(negedge clk);
        if (chk_en) compare();
        lg_en.push_back(int'(bus.wrc_en));
        lg_ready.push_back(int'(bus.req_ready));
        lg_busy.push_back(int'(busy));
        lg_addr.push_back(bus.wrc_addr);
        lg_word.push_back(bus.wrc_word);
        for (int i = 0; i < N; i++) begin
            if (bus.wrc_en[i] && bus.wrc_grnt[i]) begin
                g_idx.push_back(i);
                g_addr.push_back(bus.wrc_addr);
            end
        end
        seen_ready = bus.req_ready;
        seen_rst   = rst;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < N; i++) begin
            if (seen_rst) q[i].delete();
            else if (seen_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
    endtask

    task automatic clear_logs();
        lg_en.delete(); lg_ready.delete(); lg_busy.delete();
        lg_addr.delete(); lg_word.delete();
        g_idx.delete(); g_addr.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        bit pending;
        c = 0;
        pending = 1;
        while (pending && c < budget) begin
            pending = !model_idle();
            for (int i = 0; i < N; i++) if (q[i].size() > 0) pending = 1;
            if (pending) tick();
            c++;
        end
        chk("drain_within_budget", 64'(pending), 64'(0));
    endtask

    initial begin
        int exp_rr[7];
        bus.wrc_grnt  = '1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_addr  = '0;
        bus.req_word  = '0;

        // Reset state
        do_reset();
        chk_en = 1;
        clear_logs();
        tick();
        chk("rst_wrc_en", 64'(lg_en[0]), 64'(0));
        chk("rst_req_ready", 64'(lg_ready[0]), 64'(0));
        chk("rst_busy", 64'(lg_busy[0]), 64'(0));
        chk("rst_wrc_addr", 64'(lg_addr[0]), 64'(0));
        chk("rst_wrc_word", 64'(lg_word[0]), 64'(0));

        // Single burst: requester 2, four beats at 0x10..0x13
        do_reset();
        clear_logs();
        push_burst(2, 4, 'h10);
        for (int c = 0; c < 10; c++) tick();
        chk("sb_ready_c1", 64'(lg_ready[1]), 64'h04);
        chk("sb_en_c1", 64'(lg_en[1]), 64'h00);
        for (int c = 2; c <= 5; c++) begin
            chk("sb_en", 64'(lg_en[c]), 64'h04);
            chk("sb_addr", 64'(lg_addr[c]), 64'('h10 + c - 2));
        end
        chk("sb_en_c6", 64'(lg_en[6]), 64'h00);
        chk("sb_busy_c7", 64'(lg_busy[7]), 64'(0));

        // Round-robin among 0, 3, 5 with continuous 1-beat bursts
        do_reset();
        clear_logs();
        exp_rr = '{0, 3, 5, 0, 3, 5, 0};
        for (int c = 0; c < 80 && g_idx.size() < 7; c++) begin
            if (q[0].size() == 0) push_burst(0, 1, 'h30);
            if (q[3].size() == 0) push_burst(3, 1, 'h33);
            if (q[5].size() == 0) push_burst(5, 1, 'h35);
            tick();
        end
        chk("rr_grant_count", 64'(g_idx.size() >= 7), 64'(1));
        for (int k = 0; k < 7; k++) chk("rr_order", 64'(g_idx[k]), 64'(exp_rr[k]));
        wait_idle(100);

        // Grant stall: wrc_grnt[1] low for three cycles while beat 2 is held
        do_reset();
        clear_logs();
        push_burst(1, 4, 'h20);
        for (int c = 0; c < 12; c++) begin
            bus.wrc_grnt = (c >= 3 && c <= 5) ? ~N'(2) : '1;
            tick();
        end
        bus.wrc_grnt = '1;
        for (int c = 3; c <= 6; c++) begin
            chk("stall_addr_hold", 64'(lg_addr[c]), 64'h21);
            chk("stall_en_hold", 64'(lg_en[c]), 64'h02);
        end
        for (int c = 3; c <= 5; c++) chk("stall_ready_low", 64'(lg_ready[c]), 64'h00);
        chk("stall_ready_resume", 64'(lg_ready[6]), 64'h02);
        chk("stall_beats_granted", 64'(g_idx.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk("stall_beat_order", 64'(g_addr[k]), 64'('h20 + k));
`ifdef MVU_WRC_ARB_STATS_EN
        chk("stats_stall", 64'(stat_stall), 64'(3));
        chk("stats_beats1", 64'(stat_beats[32 +: 32]), 64'(4));
`endif

        // MAX_BURST preemption: requester 0 sends 40 beats, requester 1 waits with 2
        do_reset();
        clear_logs();
        push_burst(0, 40, 'h100);
        push_burst(1, 2, 'h200);
        for (int c = 0; c < 120 && g_idx.size() < 19; c++) tick();
        chk("mb_grant_count", 64'(g_idx.size() >= 19), 64'(1));
        for (int k = 0; k < 16; k++) begin
            chk("mb_first_owner", 64'(g_idx[k]), 64'(0));
            chk("mb_first_addr", 64'(g_addr[k]), 64'('h100 + k));
        end
        chk("mb_handover_idx", 64'(g_idx[16]), 64'(1));
        chk("mb_handover_addr", 64'(g_addr[17]), 64'h201);
        chk("mb_resume_idx", 64'(g_idx[18]), 64'(0));
        chk("mb_resume_addr", 64'(g_addr[18]), 64'h110);
        wait_idle(200);

        // Reset mid-burst with a pending beat and wrc_grnt low
        do_reset();
        push_burst(4, 1, 'h40);
        wait_idle(20);
        bus.wrc_grnt = '0;
        push_burst(4, 3, 'h50);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.wrc_grnt = '1;
        push_burst(3, 1, 'h60);
        push_burst(6, 1, 'h70);
        clear_logs();
        for (int c = 0; c < 20 && g_idx.size() < 1; c++) tick();
        chk("rm_wrc_en", 64'(lg_en[0]), 64'(0));
        chk("rm_req_ready", 64'(lg_ready[0]), 64'(0));
        chk("rm_busy", 64'(lg_busy[0]), 64'(0));
        chk("rm_next_grant", 64'(g_idx[0]), 64'(3));
        wait_idle(50);

        // Randomised traffic with random grant stalls and one reset pulse
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int r;
                r = int'($urandom_range(0, N - 1));
                if (q[r].size() < 8) push_burst(r, int'($urandom_range(1, 20)), int'($urandom));
            end
            for (int i = 0; i < N; i++) bus.wrc_grnt[i] = ($urandom_range(0, 3) != 0);
            rst = (c == 400);
            tick();
        end
        rst = 1'b0;
        bus.wrc_grnt = '1;
        wait_idle(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/mvu_wrc_arbiter.md
# mvu_wrc_arbiter

Round-robin arbiter that shares the MVU data-memory controller write port (`wrc_en` / `wrc_addr` / `wrc_word`) among the per-MVU data transposers.
- Each requester i targets MVU i and presents a write burst on a valid/ready handshake.
- The arbiter serialises the bursts onto the single shared address/word bus.
- It holds each beat until the target MVU asserts its `wrc_grnt` bit.
- It sits between the transposer array and `mvutop` in the accelerator top.

## Interface
Parameters:
- `NREQ`, default `NMVU`: number of requesters, one per MVU.
- `ADDR_W`, default `BDBANKA`: write address width.
- `DATA_W`, default `BDBANKW`: write word width.
- `MAX_BURST`, default 16: beats one owner may issue before forced rearbitration (>=1).

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: requester i has a beat.
- `req_last` input NREQ: the beat is the last of a burst.
- `req_addr` input NREQ*ADDR_W: packed beat addresses, requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_word` input NREQ*DATA_W: packed beat words.
- `req_ready` output NREQ: beat i accepted this cycle (valid & ready).
- `wrc_en` output NREQ: one-hot-or-zero MVU write enable.
- `wrc_addr` output ADDR_W: shared write address.
- `wrc_word` output DATA_W: shared write word.
- `wrc_grnt` input NREQ: MVU i accepted the held write this cycle.
- `busy` output 1: a burst is owned or an output beat is pending.

## Operation
- FSM states:
  - IDLE: no owner.
  - BURST: `owner` fixed.
  - DRAIN: last beat held in the output register, waiting for grant.
- IDLE:
  - If any `req_valid`, choose the first set bit at or after `rr_ptr` (cyclic). Set `owner` to it, clear `beat_cnt`, go to BURST next cycle.
  - `req_ready` = 0 in IDLE.
- Output register: `out_valid`, `out_idx`, `out_addr`, `out_word`.
  - `wrc_en = out_valid ? onehot(out_idx) : 0`.
  - `out_accept = out_valid & wrc_grnt[out_idx]`.
  - `wrc_grnt` bits other than `out_idx` are ignored.
- BURST:
  - `req_ready[owner] = req_valid[owner] & (!out_valid | out_accept)`; all other bits are 0.
  - On an accepted beat, load the output register and increment `beat_cnt`.
- Leaving BURST:
  - An accepted beat with `req_last`, or with `beat_cnt == MAX_BURST-1`, sets `rr_ptr = owner+1` (mod NREQ) and moves to DRAIN.
  - `req_valid[owner]` low in BURST does not release ownership; only last or MAX_BURST release it.
- DRAIN: on `out_accept`, go to IDLE. An arbitration gap of at least one cycle between bursts is intended.
- `busy = (state != IDLE) | out_valid`.
- Requirements on requesters:
  - Addr/word must be stable while valid is high and ready is low.
  - A requester must not drop valid mid-beat. Violation is flagged by an assertion in simulation.
- Reset mid-operation:
  - All state clears in the same edge; a pending beat is discarded.
  - The transposers are reset by the same signal.

## Timing
- Reset values:
  - `req_ready` = 0, `wrc_en` = 0, `wrc_addr` = 0, `wrc_word` = 0, `busy` = 0.
  - `rr_ptr` = 0, `owner` = 0, state IDLE.
- Latency from first `req_valid` (IDLE) to `wrc_en`:
  - first `req_ready` at cycle +1;
  - `wrc_en` at cycle +2.
- Throughput: 1 beat/cycle while `wrc_grnt[owner]` stays high.
- A grant-low stall holds the output register and deasserts `req_ready` in the same cycle (combinational from `wrc_grnt`).
- Burst handover cost: at minimum last-beat grant + 1 IDLE cycle + 1 BURST-entry cycle.
- `MAX_BURST = 1` degenerates to per-beat round-robin.

## Configuration
- `MVU_WRC_ARB_STATS_EN` defined:
  - Adds output `stat_beats`, NREQ*32: per-requester granted-beat counters.
  - Adds output `stat_stall`, 32: cycles with `out_valid & !out_accept`.
  - Counters wrap at 2^32 and clear on `rst`.
- Macro undefined: neither port nor any counter logic exists.

## Structure
- Shared package `mvu_pkg`:
  - `wrc_arb_state_t` enum (IDLE, BURST, DRAIN).
  - Existing `NMVU`, `BDBANKA`, `BDBANKW`.
- Sub-module `rr_pick`: combinational `NREQ`-wide round-robin priority picker (`req`, `ptr` -> `idx`, `found`). It is reusable by the future MVU read-port arbiter.

## Test plan
- Single burst:
  - Stimulus: after reset, requester 2 sends 4 beats, addr 0x10..0x13, last on the 4th; `wrc_grnt` all 1.
  - Response: `wrc_en = 0b00000100` on cycles 2..5, addrs 0x10..0x13 in order, `busy` low on cycle 7.
- Round-robin:
  - Stimulus: requesters 0, 3 and 5 all request 1-beat bursts continuously.
  - Response: grant order 0, 3, 5, 0, 3, 5; then with `rr_ptr` = 6, requester 0 is next.
- Grant stall:
  - Stimulus: requester 1 sends beats; `wrc_grnt[1]` held low 3 cycles during beat 2.
  - Response: `wrc_addr` / `wrc_word` stable for 4 cycles, `req_ready[1]` = 0 for 3 cycles, no beat lost or duplicated.
- MAX_BURST preemption:
  - Stimulus: `MAX_BURST = 16`; requester 0 sends a 40-beat burst while requester 1 waits.
  - Response: requester 0 is granted 16 beats, then requester 1's burst, then requester 0 resumes at beat 17.
- Reset mid-burst:
  - Stimulus: `rst` asserted for 1 cycle while a beat is pending with `wrc_grnt` low.
  - Response: the next cycle has `wrc_en` = 0, `req_ready` = 0, `busy` = 0, and the following grant goes to the lowest valid index from ptr 0.
- Stats (with `MVU_WRC_ARB_STATS_EN` defined):
  - Stimulus: the stall scenario above.
  - Response: `stat_stall` = 3, and `stat_beats[1]` equals the beat count.
